fwd_bypass_scoreboard: RTL
==========================

// Module: fwd_bypass_scoreboard
// PURPOSE
//  Parametrised D-stage operand bypass with built-in hazard detection; successor to the fixed 4-way forward mux.
//  Tracks the destination register and Tnew of each in-flight instruction across STAGES pipeline stages.
//  Per read port: picks the youngest ready producer's data, else the RF value; raises stall on an unresolvable RAW.
//  Sits between D-stage decode/GRF read and the D/E pipeline register.
// PARAMETERS
//  DATA_W    32  operand/result width
//  ADDR_W    5   register address width; address 0 is hard-wired zero, never tracked
//  STAGES    3   tracked stages after D (0=E, 1=M, 2=W)
//  RD_PORTS  2   D-stage read ports (rs, rt)
//  TNEW_W    2   width of Tnew/Tuse counters
// PORTS
//  clk          in   1                  clock, rising edge
//  reset        in   1                  asynchronous, active-low
//  issue_valid  in   1                  D instruction leaves D this cycle (ignored while stall=1)
//  issue_waddr  in   ADDR_W             destination register of issuing instruction (0 = no write)
//  issue_tnew   in   TNEW_W             cycles after entering E until its result exists
//  flush        in   1                  replace the entry entering stage 0 with a bubble
//  stage_wdata  in   STAGES*DATA_W      result currently held in each stage (slice k = stage k)
//  rd_addr      in   RD_PORTS*ADDR_W    register each port reads
//  rd_tuse      in   RD_PORTS*TNEW_W    cycles after D until the port's value is consumed
//  rf_data      in   RD_PORTS*DATA_W    raw GRF read data per port
//  rd_data      out  RD_PORTS*DATA_W    bypassed operand per port
//  fwd_sel      out  RD_PORTS*$clog2(STAGES+1)  0 = RF, k+1 = stage k
//  rd_fresh     out  RD_PORTS           1 = rd_data is the architecturally correct value now
//  stall        out  1                  freeze PC and D, insert bubble into stage 0
// BEHAVIOUR
//  - Per stage k registers: valid, waddr, tnew. Stages always advance every cycle; stage k -> k+1, oldest drops.
//  - Stage 0 loads {1, issue_waddr, issue_tnew} when issue_valid & ~stall & ~flush & issue_waddr!=0; else bubble (valid=0).
//  - On advance tnew decrements, saturating at 0; stage-0 load takes issue_tnew undecremented.
//  - Match(p,k) = valid_k & waddr_k==rd_addr_p & rd_addr_p!=0. Youngest (lowest k) match wins; older ignored.
//  - Winner with tnew_k==0: fwd_sel=k+1, rd_data=stage_wdata[k], rd_fresh=1.
//  - Winner with 0<tnew_k<=tuse_p: fwd_sel=0, rd_data=rf_data, rd_fresh=0, no stall (consumer re-bypasses later).
//  - Winner with tnew_k>tuse_p: stall contribution=1. stall = OR over ports.
//  - No match or rd_addr_p==0: fwd_sel=0, rd_data=rf_data (0 for addr 0 forced), rd_fresh=1.
//  - All outputs combinational from registered state + inputs; zero-latency. No combinational path from stall to stall.
//  - Simultaneous flush and stall: single bubble, no double insertion. Same-cycle issue vs read: reads see pre-issue state.
//  - Reset (async assert, sync-deassert by system): all valid=0, waddr=0, tnew=0; hence stall=0, fwd_sel=0, rd_data=rf_data, rd_fresh=1.
//  - Reset mid-operation discards all entries immediately; no stale forward after deassertion.
// STRUCTURE
//  - Shared package fwd_pkg: FWD_SEL_RF=0 constant, sel width function, TNEW_W default, stage index names E/M/W.
//  - Sub-module fwd_port_select (one per read port, generate loop): priority match, ready check, data mux, stall bit.
//  - Top holds the stage shift register and the stall OR-reduce.
// TESTING
//  1 Issue waddr=8,tnew=0; next cycle rd_addr0=8 -> fwd_sel0=1, rd_data0=stage_wdata[0], stall=0, rd_fresh0=1.
//  2 Load: issue waddr=9,tnew=2; next cycle rd_addr0=9,tuse=0 -> stall=1; cycle after (tnew=1 in M) stall=1; then fwd_sel0=3, stall=0.
//  3 Two producers of $5 in stage 0 (tnew 0) and stage 1 -> stage 0 wins, fwd_sel=1; older value never selected.
//  4 issue_waddr=0 or rd_addr=0 with stage writing 0 -> no entry/match, rd_data=0, stall=0.
//  5 flush with issue_valid=1 -> stage 0 bubble; following read of that waddr -> fwd_sel=0.
//  6 Assert reset while stall=1 -> stall=0 and fwd_sel=0 same cycle, before any clock edge.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the D-stage operand bypass scoreboard.
package fwd_pkg;

    localparam int unsigned FWD_SEL_RF = 0;
    localparam int unsigned TNEW_W_DEF = 2;

    typedef enum logic [1:0] {
        StageE = 2'd0,
        StageM = 2'd1,
        StageW = 2'd2
    } stage_e;

    function automatic int unsigned sel_w(input int unsigned stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/fwd_port_select.sv
// One read port: youngest-producer match, readiness check, operand mux and stall request.
module fwd_port_select
    import fwd_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned STAGES = 3,
    parameter int unsigned TNEW_W = TNEW_W_DEF,
    parameter int unsigned SEL_W  = sel_w(STAGES)
) (
    input  logic [STAGES-1:0]        stage_valid,
    input  logic [STAGES*ADDR_W-1:0] stage_waddr,
    input  logic [STAGES*TNEW_W-1:0] stage_tnew,
    input  logic [STAGES*DATA_W-1:0] stage_wdata,
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic [TNEW_W-1:0]        rd_tuse,
    input  logic [DATA_W-1:0]        rf_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic [SEL_W-1:0]         fwd_sel,
    output logic                     rd_fresh,
    output logic                     stall
);

    logic hit;

    always_comb begin
        hit      = 1'b0;
        rd_data  = (rd_addr == '0) ? '0 : rf_data;
        fwd_sel  = SEL_W'(FWD_SEL_RF);
        rd_fresh = 1'b1;
        stall    = 1'b0;
        // Ascending scan with a hit latch: the youngest matching stage shadows older ones.
        for (int k = 0; k < STAGES; k++) begin
            if (!hit && stage_valid[k] && rd_addr != '0 &&
                stage_waddr[k*ADDR_W +: ADDR_W] == rd_addr) begin
                hit = 1'b1;
                if (stage_tnew[k*TNEW_W +: TNEW_W] == '0) begin
                    fwd_sel = SEL_W'(k + 1);
                    rd_data = stage_wdata[k*DATA_W +: DATA_W];
                end else if (stage_tnew[k*TNEW_W +: TNEW_W] <= rd_tuse) begin
                    rd_fresh = 1'b0;
                end else begin
                    rd_fresh = 1'b0;
                    stall    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_bypass_scoreboard.sv
// D-stage operand bypass: tracks in-flight destinations/Tnew and forwards or stalls per read port.
module fwd_bypass_scoreboard
    import fwd_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned STAGES   = 3,
    parameter int unsigned RD_PORTS = 2,
    parameter int unsigned TNEW_W   = TNEW_W_DEF
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               issue_valid,
    input  logic [ADDR_W-1:0]                  issue_waddr,
    input  logic [TNEW_W-1:0]                  issue_tnew,
    input  logic                               flush,
    input  logic [STAGES*DATA_W-1:0]           stage_wdata,
    input  logic [RD_PORTS*ADDR_W-1:0]         rd_addr,
    input  logic [RD_PORTS*TNEW_W-1:0]         rd_tuse,
    input  logic [RD_PORTS*DATA_W-1:0]         rf_data,
    output logic [RD_PORTS*DATA_W-1:0]         rd_data,
    output logic [RD_PORTS*sel_w(STAGES)-1:0]  fwd_sel,
    output logic [RD_PORTS-1:0]                rd_fresh,
    output logic                               stall
);

    localparam int unsigned SEL_W = sel_w(STAGES);

    logic [STAGES-1:0]             valid_q, valid_d;
    logic [STAGES-1:0][ADDR_W-1:0] waddr_q, waddr_d;
    logic [STAGES-1:0][TNEW_W-1:0] tnew_q, tnew_d;
    logic [RD_PORTS-1:0]           port_stall;
    logic                          load;

    // stall is a function of registered state and read inputs only, so gating the load is loop-free.
    assign load  = issue_valid && !stall && !flush && (issue_waddr != '0);
    assign stall = |port_stall;

    always_comb begin
        valid_d    = '0;
        waddr_d    = '0;
        tnew_d     = '0;
        valid_d[0] = load;
        waddr_d[0] = load ? issue_waddr : '0;
        tnew_d[0]  = load ? issue_tnew : '0;
        for (int k = 1; k < STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            waddr_d[k] = waddr_q[k-1];
            tnew_d[k]  = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            waddr_q <= '0;
            tnew_q  <= '0;
        end else begin
            valid_q <= valid_d;
            waddr_q <= waddr_d;
            tnew_q  <= tnew_d;
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
        fwd_port_select #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .STAGES (STAGES),
            .TNEW_W (TNEW_W),
            .SEL_W  (SEL_W)
        ) u_sel (
            .stage_valid (valid_q),
            .stage_waddr (waddr_q),
            .stage_tnew  (tnew_q),
            .stage_wdata (stage_wdata),
            .rd_addr     (rd_addr[p*ADDR_W +: ADDR_W]),
            .rd_tuse     (rd_tuse[p*TNEW_W +: TNEW_W]),
            .rf_data     (rf_data[p*DATA_W +: DATA_W]),
            .rd_data     (rd_data[p*DATA_W +: DATA_W]),
            .fwd_sel     (fwd_sel[p*SEL_W +: SEL_W]),
            .rd_fresh    (rd_fresh[p]),
            .stall       (port_stall[p])
        );
    end

endmodule
